// File: rtl/instruction_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (sequential/branch/jump),
// IF/ID pipeline register and halt-word detection with a RUN/HALTED state machine.
module instruction_fetch_stage #(
  parameter int                     PC_WIDTH    = 7,
  parameter int                     INSTR_WIDTH = 32,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = 32'hFFFF_FFFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   jump,
  input  logic [PC_WIDTH-1:0]    jump_target,
  output logic [PC_WIDTH-1:0]    instr_addr,
  input  logic [INSTR_WIDTH-1:0] instr_data,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc_next,
  output logic                   if_id_valid,
  output logic                   halted
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [PC_WIDTH-1:0]     pc;
  logic [PC_WIDTH-1:0]     pc_next;
  logic [PC_WIDTH-1:0]     pc_plus1;
  logic                    redirect;
  logic [PC_WIDTH-1:0]     redirect_target;
  logic                    fetch_halt;
  logic [INSTR_WIDTH-1:0]  if_id_instr_next;
  logic [PC_WIDTH-1:0]     if_id_pc_next_next;
  logic                    if_id_valid_next;

  assign pc_plus1        = pc + PC_WIDTH'(1);
  assign redirect        = branch_taken | jump;
  // Branch wins when both redirect sources fire together.
  assign redirect_target = branch_taken ? branch_target : jump_target;
  assign fetch_halt      = (state == RUN) && (instr_data == HALT_WORD) &&
                           !redirect && !stall && !flush;
  assign instr_addr      = pc;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (fetch_halt) state_next = HALTED;
      HALTED:  if (redirect)   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Output logic
  always_comb begin
    halted = (state == HALTED);
  end

  // Next PC: redirect, then hold (stall, halted, or halt word just fetched), then sequential.
  always_comb begin
    pc_next = pc_plus1;
    if (redirect) begin
      pc_next = redirect_target;
    end else if (stall || (state == HALTED) || fetch_halt) begin
      pc_next = pc;
    end
  end

  always_comb begin
    if_id_instr_next   = instr_data;
    if_id_pc_next_next = pc_plus1;
    if_id_valid_next   = 1'b1;
    if (flush || redirect) begin
      if_id_instr_next   = '0;
      if_id_pc_next_next = '0;
      if_id_valid_next   = 1'b0;
    end else if (stall) begin
      if_id_instr_next   = if_id_instr;
      if_id_pc_next_next = if_id_pc_next;
      if_id_valid_next   = if_id_valid;
    end else if (state == HALTED) begin
      if_id_instr_next   = '0;
      if_id_pc_next_next = '0;
      if_id_valid_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc            <= '0;
      if_id_instr   <= '0;
      if_id_pc_next <= '0;
      if_id_valid   <= 1'b0;
    end else begin
      pc            <= pc_next;
      if_id_instr   <= if_id_instr_next;
      if_id_pc_next <= if_id_pc_next_next;
      if_id_valid   <= if_id_valid_next;
    end
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Instruction-fetch stage of the pipelined processor. It holds the program counter, computes the sequential next PC (PC+1, word-addressed), and presents the PC to the instruction memory. It selects the next PC from sequential, branch or jump sources and latches the fetched instruction into the IF/ID pipeline register for the decode stage. It also detects the halt word and stops fetching until a redirect or reset.

## Interface
Parameters:
- PC_WIDTH, 7, PC and target width (word addresses, 128-word instruction memory)
- INSTR_WIDTH, 32, instruction word width
- HALT_WORD, 32'hFFFF_FFFF, encoding that stops fetch

Ports:
- clk  in  1  single system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- stall  in  1  hazard unit: hold PC and IF/ID contents
- flush  in  1  replace the IF/ID contents with a bubble on the next edge
- branch_taken  in  1  branch resolved taken this cycle
- branch_target  in  PC_WIDTH  branch destination
- jump  in  1  unconditional jump this cycle
- jump_target  in  PC_WIDTH  jump destination
- instr_addr  out  PC_WIDTH  current PC driven to instruction memory (= pc register)
- instr_data  in  INSTR_WIDTH  combinational memory read data for instr_addr
- if_id_instr  out  INSTR_WIDTH  latched instruction
- if_id_pc_next  out  PC_WIDTH  latched PC+1 of that instruction
- if_id_valid  out  1  latched instruction is real (0 = bubble)
- halted  out  1  fetch is stopped in HALTED state

## Operation
- pc_plus1 = pc + 1, modulo 2^PC_WIDTH (7'h7F wraps to 7'h00, no carry out).
- redirect = branch_taken | jump. If both are asserted, branch_taken wins and the PC loads branch_target.
- Next-PC priority, highest first: redirect target; hold (stall or HALTED); pc_plus1.
- IF/ID update priority, highest first:
  - flush or redirect: bubble (instr=0, pc_next=0, valid=0).
  - stall: hold all three fields.
  - HALTED: bubble.
  - Otherwise: instr=instr_data, pc_next=pc_plus1, valid=1.
- State machine, 2 states:
  - RUN: when instr_data==HALT_WORD, no redirect, no stall and no flush, IF/ID latches the halt word (valid=1), the PC holds, and the state moves to HALTED.
  - HALTED: halted=1 and the PC holds. A redirect loads its target and returns to RUN. stall and flush have no effect on the state.
- A redirect in the same cycle as a HALT_WORD fetch: the redirect wins, the state stays RUN, and IF/ID takes a bubble.
- Reset values: pc=0, instr_addr=0, if_id_instr=0, if_id_pc_next=0, if_id_valid=0, halted=0, state=RUN.

## Timing
- PC register and IF/ID register both update on the rising edge of clk.
- instr_addr is registered; instr_data is combinational, so each fetch is single-cycle.
- Fetch-to-decode latency is 1 cycle: the instruction at PC p appears on if_id_instr the edge after instr_addr=p.
- Redirect penalty is 1 bubble. The target is on instr_addr the cycle after the redirect, and its instruction reaches IF/ID one edge later.
- stall held N cycles freezes PC and IF/ID for exactly N edges. Sequential fetch resumes on the first edge with stall=0.
- halted rises on the same edge that latches the halt word into IF/ID.
- Reset mid-operation: all outputs clear asynchronously without waiting for clk. The first fetch after reset deassertion is address 0.

## Test plan
- Sequential fetch: memory word k = 32'h1000_0000+k, no control inputs. Required: instr_addr steps 0,1,2,3. if_id_instr = 32'h1000_0000 with pc_next=1 and valid=1 one edge after addr 0.
- Wrap-around: jump to 7'h7E, then run free. Required: instr_addr sequence 7E, 7F, 00. IF/ID for addr 7F shows pc_next=0.
- Stall/flush: at pc=5, stall for 3 cycles. Required: pc stays 5 and IF/ID holds the addr-4 instruction for 3 edges. Then flush for 1 cycle. Required: valid=0 and pc=6.
- Redirect priority: branch_taken=1 with target 7'h20 and jump=1 with target 7'h40, both together. Required: instr_addr=7'h20 next cycle and IF/ID bubble (valid=0).
- Halt: put HALT_WORD at addr 3. Required: halted=1 after the edge that latches addr 3. pc stays 3, and subsequent IF/ID entries are bubbles. A branch to 7'h10 then clears halted and fetches from 7'h10.
- Async reset: assert reset mid-cycle while pc=9. Required: all outputs are 0 before the next clk edge, and fetch restarts at addr 0 after release.
